vga_mode_ctrl: RTL and testbench

VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

---
 rtl/vga_mode_ctrl.sv | 142 ++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_ctrl.sv
// Display-mode selector for a VGA pattern generator. Button and auto-cycle requests
// are latched and applied only at the vertical-sync boundary.
module vga_mode_ctrl #(
  parameter int NUM_MODES   = 6,
  parameter int DB_CYCLES   = 1000000,
  parameter int AUTO_FRAMES = 120
) (
  input  logic       system_clk,
  input  logic       RST,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  input  logic       vsync,
  output logic [2:0] ena,
  output logic       frame_tick,
  output logic       pending
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(AUTO_FRAMES - 1);
  localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_NEXT = 2'd1, REQ_PREV = 2'd2} req_e;

  // Out-of-range codes fold back into the legal range so ena can never escape it.
  function automatic logic [2:0] step_next(input logic [2:0] e);
    return (e >= MODE_LAST) ? 3'd0 : e + 3'd1;
  endfunction

  function automatic logic [2:0] step_prev(input logic [2:0] e);
    return (e == 3'd0 || e > MODE_LAST) ? MODE_LAST : e - 3'd1;
  endfunction

  logic [1:0]    btn_s1_q, btn_s2_q;   // bit 0 = next, bit 1 = prev
  logic          auto_s1_q, auto_s2_q;
  logic          vs_s1_q, vs_s2_q, vs_prev_q;
  logic [1:0]    db_q, db_d, db_dly_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic          tick_q, tick_d;
  logic [2:0]    ena_q, ena_d;
  req_e          req_q, req_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [1:0]    press_s;
  logic          next_ev_s, prev_ev_s;

  always_ff @(posedge system_clk or posedge RST) begin
    if (RST) begin
      btn_s1_q  <= 2'b00;
      btn_s2_q  <= 2'b00;
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      btn_s1_q  <= {btn_prev, btn_next};
      btn_s2_q  <= btn_s1_q;
      auto_s1_q <= auto_en;
      auto_s2_q <= auto_s1_q;
      vs_s1_q   <= vsync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
    end
  end

  // The counter measures how long the synchronized input has disagreed with the debounced state.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign press_s   = db_q & ~db_dly_q;
  assign next_ev_s = press_s[0] & ~press_s[1];
  assign prev_ev_s = press_s[1] & ~press_s[0];

  // A press in the tick cycle lands after the apply, so it survives into the next frame.
  always_comb begin
    ena_d   = ena_q;
    req_d   = req_q;
    frame_d = frame_q;
    tick_d  = vs_prev_q & ~vs_s2_q;
    if (tick_q) begin
      case (req_q)
        REQ_NEXT: ena_d = step_next(ena_q);
        REQ_PREV: ena_d = step_prev(ena_q);
        default: begin
          if (auto_s2_q && frame_q == FR_LAST) ena_d = step_next(ena_q);
          else                                 ena_d = ena_q;
        end
      endcase
      req_d = REQ_NONE;
    end else begin
      ena_d = ena_q;
    end
    if (next_ev_s)      req_d = REQ_NEXT;
    else if (prev_ev_s) req_d = REQ_PREV;
    else                req_d = req_d;
    if (!auto_s2_q || (|press_s)) frame_d = '0;
    else if (tick_q)              frame_d = (frame_q == FR_LAST) ? '0 : frame_q + FW'(1);
    else                          frame_d = frame_q;
  end

  always_ff @(posedge system_clk or posedge RST) begin
    if (RST) begin
      db_q     <= 2'b00;
      db_dly_q <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      tick_q   <= 1'b0;
      ena_q    <= 3'd0;
      req_q    <= REQ_NONE;
      frame_q  <= '0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      tick_q   <= tick_d;
      ena_q    <= ena_d;
      req_q    <= req_d;
      frame_q  <= frame_d;
    end
  end

  assign ena        = ena_q;
  assign frame_tick = tick_q;
  assign pending    = (req_q != REQ_NONE);

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a frame/mode-level reference model.
module tb_vga_mode_ctrl;
  localparam int NM = 6;
  localparam int DB = 4;
  localparam int AF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0, vsync = 1'b1;
  logic [2:0] ena;
  logic       frame_tick, pending;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  vga_mode_ctrl #(.NUM_MODES(NM), .DB_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
    .system_clk(clk), .RST(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .vsync(vsync), .ena(ena), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: input pipelines, sample windows for debouncing, mode arithmetic mod NM.
  logic          mn1, mn2, mp1, mp2, ma1, ma2, mv1, mv2, mvprev, m_tick;
  logic          m_db_n, m_db_p, m_dbd_n, m_dbd_p;
  logic [DB-1:0] m_win_n, m_win_p;
  int            m_ena, m_req, m_frames;

  always @(posedge clk or posedge rst) begin : model
    logic pn, pp;
    logic [DB-1:0] wn, wp;
    int e, r;
    if (rst) begin
      {mn1, mn2, mp1, mp2, ma1, ma2} <= 6'b0;
      {mv1, mv2, mvprev} <= 3'b111;
      m_tick <= 1'b0;
      {m_db_n, m_db_p, m_dbd_n, m_dbd_p} <= 4'b0;
      m_win_n <= '0;
      m_win_p <= '0;
      m_ena <= 0;
      m_req <= 0;
      m_frames <= 0;
    end else begin
      pn = m_db_n & ~m_dbd_n;
      pp = m_db_p & ~m_dbd_p;
      e = m_ena;
      r = m_req;
      if (m_tick) begin
        if (r == 1)                       e = (e + 1) % NM;
        else if (r == 2)                  e = (e + NM - 1) % NM;
        else if (ma2 && m_frames == AF-1) e = (e + 1) % NM;
        r = 0;
      end
      if (pn != pp) r = pn ? 1 : 2;
      m_ena <= e;
      m_req <= r;
      if (!ma2 || pn || pp) m_frames <= 0;
      else if (m_tick)      m_frames <= (m_frames + 1) % AF;
      // Debounced level flips once the last DB synchronized samples all disagree with it.
      wn = {m_win_n[DB-2:0], mn2};
      wp = {m_win_p[DB-2:0], mp2};
      m_win_n <= wn;
      m_win_p <= wp;
      m_db_n  <= (wn == {DB{~m_db_n}}) ? ~m_db_n : m_db_n;
      m_db_p  <= (wp == {DB{~m_db_p}}) ? ~m_db_p : m_db_p;
      m_dbd_n <= m_db_n;
      m_dbd_p <= m_db_p;
      m_tick  <= mvprev & ~mv2;
      mvprev  <= mv2;
      {mn2, mn1} <= {mn1, btn_next};
      {mp2, mp1} <= {mp1, btn_prev};
      {ma2, ma1} <= {ma1, auto_en};
      {mv2, mv1} <= {mv1, vsync};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      check("ena_vs_model", int'(ena), m_ena);
      check("frame_tick_vs_model", int'(frame_tick), int'(m_tick));
      check("pending_vs_model", int'(pending), int'(m_req != 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit prev);
    @(negedge clk);
    if (prev) btn_prev = 1'b1; else btn_next = 1'b1;
    cyc(10);
    btn_prev = 1'b0;
    btn_next = 1'b0;
    cyc(10);
  endtask

  task automatic vpulse();
    @(negedge clk);
    vsync = 1'b0;
    cyc(3);
    vsync = 1'b1;
    cyc(6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc(2);
    check("reset_ena", int'(ena), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_frame_tick", int'(frame_tick), 0);

    // Clean next press, applied at the following frame boundary.
    press(1'b0);
    check("s1_pending_latched", int'(pending), 1);
    check("s1_model_pending", int'(m_req != 0), 1);
    vpulse();
    check("s1_ena_after_tick", int'(ena), 1);
    check("s1_pending_cleared", int'(pending), 0);

    // Three-cycle glitch is shorter than the debounce window.
    @(negedge clk);
    btn_next = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    cyc(10);
    check("s2_glitch_no_pending", int'(pending), 0);
    vpulse();
    check("s2_glitch_ena_kept", int'(ena), 1);

    // Wrap in both directions.
    do_reset();
    check("s3_reset_ena", int'(ena), 0);
    press(1'b1);
    vpulse();
    check("s3_prev_wrap", int'(ena), 5);
    check("s3_model_prev_wrap", m_ena, 5);
    press(1'b0);
    vpulse();
    check("s3_next_wrap", int'(ena), 0);

    // Auto-cycling every AF frames, frozen when disabled.
    @(negedge clk);
    auto_en = 1'b1;
    cyc(4);
    repeat (3) vpulse();
    check("s4_auto_step1", int'(ena), 1);
    repeat (3) vpulse();
    check("s4_auto_step2", int'(ena), 2);
    check("s4_model_auto_step2", m_ena, 2);
    @(negedge clk);
    auto_en = 1'b0;
    cyc(4);
    repeat (4) vpulse();
    check("s4_auto_off_frozen", int'(ena), 2);

    // Latest request wins; simultaneous presses cancel out.
    press(1'b0);
    vpulse();
    check("s5_ena3", int'(ena), 3);
    press(1'b0);
    press(1'b1);
    vpulse();
    check("s5_latest_wins", int'(ena), 2);
    @(negedge clk);
    btn_next = 1'b1;
    btn_prev = 1'b1;
    cyc(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc(10);
    check("s5_both_no_pending", int'(pending), 0);
    vpulse();
    check("s5_both_ena_kept", int'(ena), 2);

    // Reset while a request is pending discards it.
    press(1'b0);
    vpulse();
    press(1'b0);
    vpulse();
    check("s6_ena4", int'(ena), 4);
    press(1'b0);
    check("s6_pending_before_rst", int'(pending), 1);
    @(negedge clk);
    vsync = 1'b0;
    rst = 1'b1;
    #1;
    check("s6_rst_ena_immediate", int'(ena), 0);
    check("s6_rst_pending_immediate", int'(pending), 0);
    cyc(2);
    rst = 1'b0;
    vsync = 1'b1;
    cyc(3);
    vpulse();
    check("s6_no_change_after_rst", int'(ena), 0);
    check("s6_no_pending_after_rst", int'(pending), 0);

    // Random phase: bouncy buttons, random vsync and auto_en, occasional reset pulses.
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      rst = 1'b0;
      case ($urandom_range(0, 11))
        0, 1, 2: btn_next = ~btn_next;
        3, 4, 5: btn_prev = ~btn_prev;
        6:       auto_en  = ~auto_en;
        7, 8, 9: vsync    = ~vsync;
        10:      rst      = ($urandom_range(0, 7) == 0);
        default: ;
      endcase
      cyc($urandom_range(0, 8));
    end
    rst = 1'b0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
